// File: rtl/if_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module   : if_weight_loader
//  Brief    : Streams a valid/ready burst of weights into consecutive word
//             addresses of one IF-network layer through the network's
//             mem_addr/mem_din/mem_wen/mem_dout port.
//             Optional read-back checking is built when the macro
//             IF_WEIGHT_LOADER_VERIFY_EN is defined: the burst is re-read and
//             an XOR checksum of the read data is compared with the written one.
//             READ_LATENCY must be at least 1.
//  Revision : 1.0  initial release
// ============================================================================
module if_weight_loader #(
    parameter int WEIGHT_SIZE      = 32,
    parameter int LAYER_ADDR_WIDTH = 28,
    parameter int CNT_WIDTH        = 16,
    parameter int READ_LATENCY     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [3:0]                  layer_sel,
    input  logic [LAYER_ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]        count,
    input  logic                        s_valid,
    input  logic [WEIGHT_SIZE-1:0]      s_data,
    output logic                        s_ready,
    output logic [31:0]                 mem_addr,
    output logic [WEIGHT_SIZE-1:0]      mem_din,
    output logic                        mem_wen,
    input  logic [WEIGHT_SIZE-1:0]      mem_dout,
    output logic                        busy,
    output logic                        done,
    output logic                        verify_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
`ifdef IF_WEIGHT_LOADER_VERIFY_EN
        S_VERIFY = 2'd2,
`endif
        S_DONE   = 2'd3
    } state_t;

`ifdef IF_WEIGHT_LOADER_VERIFY_EN
    localparam state_t c_POST_WRITE = S_VERIFY;
`else
    localparam state_t c_POST_WRITE = S_DONE;
`endif

    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    state_t                      r_state;
    state_t                      w_next;

    logic [3:0]                  r_layer;
    logic [LAYER_ADDR_WIDTH-1:0] r_base;
    logic [CNT_WIDTH-1:0]        r_count;
    logic [CNT_WIDTH-1:0]        r_idx;

    logic                        r_s_ready;
    logic                        r_mem_wen;
    logic                        r_busy;
    logic                        r_done;
    logic [31:0]                 r_mem_addr;
    logic [WEIGHT_SIZE-1:0]      r_mem_din;

    logic                        w_start_acc;
    logic                        w_beat;
    logic                        w_last_beat;
    logic [LAYER_ADDR_WIDTH-1:0] w_wr_off;
    logic [31:0]                 w_wr_addr;

    // Start is only honoured in IDLE; a start during a burst is dropped.
    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_beat      = (r_state == S_WRITE) && r_s_ready && s_valid;
    assign w_last_beat = w_beat && (r_idx == (r_count - c_CNT_ONE));

    // In-layer offset wraps modulo 2^LAYER_ADDR_WIDTH and never reaches the layer field.
    assign w_wr_off  = r_base + LAYER_ADDR_WIDTH'(r_idx);
    assign w_wr_addr = 32'({r_layer, w_wr_off});

`ifdef IF_WEIGHT_LOADER_VERIFY_EN
    logic [WEIGHT_SIZE-1:0]      r_wr_xor;
    logic [WEIGHT_SIZE-1:0]      r_rd_xor;
    logic [CNT_WIDTH-1:0]        r_vidx;
    logic [READ_LATENCY:0]       r_rd_vld;
    logic [READ_LATENCY:0]       r_rd_tag;
    logic                        r_verify_err;
    logic                        w_issue;
    logic                        w_issue_last;
    logic                        w_cap;
    logic                        w_cap_last;
    logic                        w_rd_last_pend;
    logic [LAYER_ADDR_WIDTH-1:0] w_rd_off;
    logic [31:0]                 w_rd_addr;

    // Read addresses are issued back to back; the tag marks the final one so the
    // FSM can leave VERIFY exactly when the last read data is about to arrive.
    assign w_issue        = (r_state == S_VERIFY) && (r_vidx != r_count);
    assign w_issue_last   = w_issue && (r_vidx == (r_count - c_CNT_ONE));
    assign w_cap          = r_rd_vld[READ_LATENCY];
    assign w_cap_last     = r_rd_tag[READ_LATENCY];
    assign w_rd_last_pend = r_rd_tag[READ_LATENCY-1];
    assign w_rd_off       = r_base + LAYER_ADDR_WIDTH'(r_vidx);
    assign w_rd_addr      = 32'({r_layer, w_rd_off});

    // Checksums, read-issue index, read-data alignment pipe and the sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_xor     <= '0;
            r_rd_xor     <= '0;
            r_vidx       <= '0;
            r_rd_vld     <= '0;
            r_rd_tag     <= '0;
            r_verify_err <= 1'b0;
        end else begin
            r_rd_vld <= {r_rd_vld[READ_LATENCY-1:0], w_issue};
            r_rd_tag <= {r_rd_tag[READ_LATENCY-1:0], w_issue_last};
            if (w_start_acc) begin
                r_wr_xor     <= '0;
                r_rd_xor     <= '0;
                r_vidx       <= '0;
                r_verify_err <= 1'b0;
            end else begin
                if (w_beat) begin
                    r_wr_xor <= r_wr_xor ^ s_data;
                end
                if (w_issue) begin
                    r_vidx <= r_vidx + c_CNT_ONE;
                end
                if (w_cap) begin
                    r_rd_xor <= r_rd_xor ^ mem_dout;
                end
                if (w_cap_last) begin
                    r_verify_err <= ((r_rd_xor ^ mem_dout) != r_wr_xor);
                end
            end
        end
    end

    assign verify_err = r_verify_err;
`else
    logic w_unused_sink;
    assign w_unused_sink = ^{mem_dout, READ_LATENCY[0]};
    assign verify_err    = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (count == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_last_beat) begin
                    w_next = c_POST_WRITE;
                end
            end
`ifdef IF_WEIGHT_LOADER_VERIFY_EN
            S_VERIFY: begin
                if (w_rd_last_pend) begin
                    w_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register plus the status outputs derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_s_ready <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_busy    <= (w_next != S_IDLE);
            r_s_ready <= (w_next == S_WRITE);
            r_done    <= (r_state == S_DONE);
        end
    end

    // Burst descriptor capture and write index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_layer <= '0;
            r_base  <= '0;
            r_count <= '0;
            r_idx   <= '0;
        end else if (w_start_acc) begin
            r_layer <= layer_sel;
            r_base  <= base_addr;
            r_count <= count;
            r_idx   <= '0;
        end else if (w_beat) begin
            r_idx   <= r_idx + c_CNT_ONE;
        end
    end

    // Memory port: one registered write per accepted beat, reads during VERIFY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_wen  <= 1'b0;
        end else begin
            r_mem_wen <= w_beat;
            if (w_beat) begin
                r_mem_addr <= w_wr_addr;
                r_mem_din  <= s_data;
            end
`ifdef IF_WEIGHT_LOADER_VERIFY_EN
            else if (w_issue) begin
                r_mem_addr <= w_rd_addr;
            end
`endif
        end
    end

    assign s_ready  = r_s_ready;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign mem_wen  = r_mem_wen;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_if_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_weight_loader
//  Brief    : Self-checking bench for if_weight_loader: directed vector table,
//             reset/abort sequences, randomized bursts against a reference model.
//             Read-back tests are included when IF_WEIGHT_LOADER_VERIFY_EN is set.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_weight_loader;

    localparam int RL = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  layer_sel;
    logic [27:0] base_addr;
    logic [15:0] count;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_wen;
    logic [31:0] mem_dout;
    logic        busy;
    logic        done;
    logic        verify_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural memory with a fixed read latency and an optional corrupted word.
    logic [31:0] mem_model [0:1023];
    logic [31:0] apipe     [0:RL-1];
    logic        corrupt_en;
    logic [31:0] corrupt_addr;

    if_weight_loader #(
        .WEIGHT_SIZE     (32),
        .LAYER_ADDR_WIDTH(28),
        .CNT_WIDTH       (16),
        .READ_LATENCY    (RL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .layer_sel (layer_sel),
        .base_addr (base_addr),
        .count     (count),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_wen   (mem_wen),
        .mem_dout  (mem_dout),
        .busy      (busy),
        .done      (done),
        .verify_err(verify_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        apipe[0] <= mem_addr;
        for (int i = 1; i < RL; i++) apipe[i] <= apipe[i-1];
        if (mem_wen) mem_model[mem_addr[9:0]] <= mem_din;
    end

    assign mem_dout = mem_model[apipe[RL-1][9:0]] ^
                      ((corrupt_en && (apipe[RL-1] == corrupt_addr)) ? 32'h1 : 32'h0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Runs one burst starting at the current negedge; checks every cycle against
    // the model: a write appears exactly one cycle after each accepted beat, at
    // {layer, (base + k) mod 2^28} with the beat's data.
    task automatic run_burst(input logic [3:0] lay, input logic [27:0] base,
                             input logic [15:0] cnt, input int vmode, input int poke,
                             input bit corrupt, output int lat, output int nwr,
                             output logic [31:0] fa, output logic [31:0] la);
        int          accepted;
        bit          beat_prev;
        bit          finished;
        bit          v;
        int          budget;
        logic [31:0] exp_a;
        logic [31:0] exp_d;
        logic [27:0] coff;
        accepted  = 0;
        beat_prev = 0;
        finished  = 0;
        nwr       = 0;
        lat       = -1;
        fa        = '0;
        la        = '0;
        exp_a     = '0;
        exp_d     = '0;
        budget    = 4 * int'(cnt) + 40;
        coff         = base + 28'(cnt >> 1);
        corrupt_en   = corrupt;
        corrupt_addr = {lay, coff};
        layer_sel = lay;
        base_addr = base;
        count     = cnt;
        start     = 1'b1;
        s_valid   = 1'b0;
        for (int n = 1; n <= budget && !finished; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == poke) begin
                start     = 1'b1;
                layer_sel = ~lay;
                base_addr = base + 28'h333;
                count     = cnt + 16'd7;
            end
            chk("mem_wen", mem_wen, beat_prev);
            if (mem_wen) begin
                if (beat_prev) begin
                    chk("mem_addr", mem_addr, exp_a);
                    chk("mem_din", mem_din, exp_d);
                end
                if (nwr == 0) fa = mem_addr;
                la = mem_addr;
                nwr++;
            end
`ifdef IF_WEIGHT_LOADER_VERIFY_EN
            if (n == 1) chk("verify_err_clear", verify_err, 1'b0);
`endif
            if (done) begin
                lat      = n;
                finished = 1;
                chk("busy_at_done", busy, 1'b0);
`ifdef IF_WEIGHT_LOADER_VERIFY_EN
                chk("verify_err", verify_err, corrupt);
`endif
            end else begin
                chk("busy", busy, 1'b1);
                chk("s_ready", s_ready, accepted < int'(cnt));
                case (vmode)
                    0:       v = 1'b1;
                    1:       v = n[0];
                    default: v = ($urandom_range(0, 1) == 1);
                endcase
                s_valid   = v;
                s_data    = $urandom;
                beat_prev = v && s_ready;
                if (beat_prev) begin
                    exp_a = {lay, 28'(base + 28'(accepted))};
                    exp_d = s_data;
                    accepted++;
                end
            end
        end
        s_valid = 1'b0;
        start   = 1'b0;
        if (!finished) chk("done_timeout", 1'b0, 1'b1);
        corrupt_en = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  layer;
        logic [27:0] base;
        logic [15:0] cnt;
        int          vmode;
        int          poke;
        int          exp_lat;
        int          exp_nwr;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vt [0:6];

    initial begin
        int          lat;
        int          nwr;
        int          exp_lat;
        logic [31:0] fa;
        logic [31:0] la;
        logic [3:0]  r_lay;
        logic [27:0] r_base;
        logic [15:0] r_cnt;
        bit          r_cor;

        //           layer  base          cnt  vm poke lat nwr first          last
        vt[0] = '{4'h1, 28'h0000010, 16'd4, 0, 0,  6,  4, 32'h1000_0010, 32'h1000_0013};
        vt[1] = '{4'h1, 28'hFFF_FFFF, 16'd2, 0, 0,  4,  2, 32'h1FFF_FFFF, 32'h1000_0000};
        vt[2] = '{4'h7, 28'h0000055, 16'd0, 0, 0,  2,  0, 32'h0,          32'h0};
        vt[3] = '{4'hF, 28'hFFF_FFFE, 16'd3, 0, 0,  5,  3, 32'hFFFF_FFFE, 32'hF000_0000};
        vt[4] = '{4'h2, 28'h0000100, 16'd5, 1, 0, 11,  5, 32'h2000_0100, 32'h2000_0104};
        vt[5] = '{4'h3, 28'h0002000, 16'd1, 0, 0,  3,  1, 32'h3000_2000, 32'h3000_2000};
        vt[6] = '{4'h5, 28'h0000080, 16'd4, 0, 2,  6,  4, 32'h5000_0080, 32'h5000_0083};

        rst          = 1'b1;
        start        = 1'b0;
        layer_sel    = '0;
        base_addr    = '0;
        count        = '0;
        s_valid      = 1'b0;
        s_data       = '0;
        corrupt_en   = 1'b0;
        corrupt_addr = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_din", mem_din, 32'h0);
        chk("rst_mem_wen", mem_wen, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_verify_err", verify_err, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_done", done, 1'b0);
        chk("post_rst_mem_wen", mem_wen, 1'b0);

        // Directed vector table.
        for (int i = 0; i < 7; i++) begin
            run_burst(vt[i].layer, vt[i].base, vt[i].cnt, vt[i].vmode, vt[i].poke, 1'b0,
                      lat, nwr, fa, la);
            exp_lat = vt[i].exp_lat;
`ifdef IF_WEIGHT_LOADER_VERIFY_EN
            if (vt[i].cnt != 0) exp_lat = exp_lat + int'(vt[i].cnt) + RL;
`endif
            chk($sformatf("vec%0d_latency", i), lat, exp_lat);
            chk($sformatf("vec%0d_writes", i), nwr, vt[i].exp_nwr);
            if (vt[i].exp_nwr > 0) begin
                chk($sformatf("vec%0d_first_addr", i), fa, vt[i].exp_first);
                chk($sformatf("vec%0d_last_addr", i), la, vt[i].exp_last);
            end
            @(negedge clk);
        end

        // Reset in the middle of a burst: outputs clear at once and no done follows.
        layer_sel = 4'h1;
        base_addr = 28'h40;
        count     = 16'd6;
        start     = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h1111;
        @(negedge clk);
        s_data  = 32'h2222;
        @(negedge clk);
        chk("abort_second_write", mem_wen, 1'b1);
        chk("abort_second_addr", mem_addr, 32'h1000_0041);
        rst = 1'b0;
        #1;
        chk("abort_mem_wen", mem_wen, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_s_ready", s_ready, 1'b0);
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("abort_no_done", done, 1'b0);
            chk("abort_no_write", mem_wen, 1'b0);
        end

`ifdef IF_WEIGHT_LOADER_VERIFY_EN
        // Read-back: clean burst, then a corrupted word, then hold and clear.
        run_burst(4'h6, 28'h200, 16'd8, 0, 0, 1'b0, lat, nwr, fa, la);
        chk("verify_clean_latency", lat, 8 + 2 + 8 + RL);
        @(negedge clk);
        run_burst(4'h6, 28'h300, 16'd8, 0, 0, 1'b1, lat, nwr, fa, la);
        chk("verify_bad_latency", lat, 8 + 2 + 8 + RL);
        repeat (3) @(negedge clk);
        chk("verify_err_held", verify_err, 1'b1);
        run_burst(4'h6, 28'h400, 16'd2, 0, 0, 1'b0, lat, nwr, fa, la);
        @(negedge clk);
`endif

        // Randomized bursts, random backpressure, bases near the wrap point.
        for (int t = 0; t < 24; t++) begin
            r_lay  = 4'($urandom);
            r_cnt  = 16'($urandom_range(0, 12));
            r_base = ($urandom_range(0, 3) == 0) ? (28'hFFF_FFFF - 28'($urandom_range(0, 5)))
                                                 : 28'($urandom);
`ifdef IF_WEIGHT_LOADER_VERIFY_EN
            r_cor = (r_cnt != 0) && ($urandom_range(0, 1) == 1);
`else
            r_cor = 1'b0;
`endif
            run_burst(r_lay, r_base, r_cnt, 2, 0, r_cor, lat, nwr, fa, la);
            chk("rand_writes", nwr, int'(r_cnt));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
